uart_tx_queue: RTL and testbench

Byte FIFO plus feeder FSM that sits directly upstream of the UART transmitter. Accepts bytes from the CPU/bus side at clk rate and drives the transmitter's start_n/data/ready_to_send handshake, one byte per frame. Gives software a fire-and-forget transmit path instead of polling ready_to_send per byte.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_queue.sv | 88 ++++++++
 tb/tb_uart_tx_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX feeder state encoding.
// Kept separate so the RX side can reuse the same types.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_BUSY,
    WAIT_READY
  } feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with registered full/empty/count; head is read combinationally.
// Push is accepted on a full FIFO only if a pop occurs on the same edge; otherwise it is dropped and overflow sticks.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [DEPTH_LOG2:0]   count_nxt;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == COUNT_FULL);
      empty <= (count_nxt == '0);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage is not reset; empty guards every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter via start_n/data/ready handshake; request issued one edge after non-empty && ready.
// Writer is never stalled: writes to a full queue are dropped and flagged; the feeder waits on uart_ready indefinitely.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2       = 4,
  parameter int START_PULSE_CLKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [BYTE_W-1:0]   wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  input  logic                uart_ready,
  output logic                uart_start_n,
  output logic [BYTE_W-1:0]   uart_data
);

  localparam int CNT_W = (START_PULSE_CLKS > 2) ? $clog2(START_PULSE_CLKS) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(START_PULSE_CLKS - 1);

  feed_state_t       state;
  logic [CNT_W-1:0]  pulse_cnt;
  logic [BYTE_W-1:0] head;
  logic              pop;

  // The transmitter dropping ready marks the moment it has latched the byte.
  assign pop = (state == WAIT_BUSY) && !uart_ready;

  sync_fifo #(
    .WIDTH      (BYTE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pulse_cnt    <= '0;
      uart_start_n <= 1'b1;
      uart_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_start_n <= 1'b1;
          if (!empty && uart_ready) begin
            uart_data    <= head;
            uart_start_n <= 1'b0;
            pulse_cnt    <= PULSE_LAST;
            state        <= REQ;
          end
        end
        REQ: begin
          if (pulse_cnt == '0) begin
            uart_start_n <= 1'b1;
            state        <= WAIT_BUSY;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (!uart_ready) state <= WAIT_READY;
        end
        WAIT_READY: begin
          if (uart_ready) state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          uart_start_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple transmitter handshake model.
module tb_uart_tx_queue;

  localparam int FRAME = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       man_ready;
  logic       model_ready = 1'b1;
  logic       model_en    = 1'b0;
  logic       uart_ready;
  logic       uart_start_n;
  logic [7:0] uart_data;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] cap_q[$];
  logic [7:0] exp_b;
  bit         seen_low;

  assign uart_ready = model_en ? model_ready : man_ready;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DEPTH_LOG2       (4),
    .START_PULSE_CLKS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .uart_ready   (uart_ready),
    .uart_start_n (uart_start_n),
    .uart_data    (uart_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_sn(input logic lvl, input int budget, input string tag);
    int k = 0;
    while (uart_start_n !== lvl && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(uart_start_n), 32'(lvl));
  endtask

  task automatic wait_caps(input int n, input int budget, input string tag);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(cap_q.size()), 32'(n));
  endtask

  // Transmitter stand-in: latches data one tick after a 1->0 start_n edge, then is busy for a frame.
  initial begin
    logic prev_sn;
    prev_sn = 1'b1;
    forever begin
      tick();
      if (model_en && model_ready && prev_sn && !uart_start_n) begin
        tick();
        cap_q.push_back(uart_data);
        model_ready = 1'b0;
        repeat (FRAME) tick();
        model_ready = 1'b1;
      end
      prev_sn = uart_start_n;
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; man_ready = 1'b0;
    repeat (2) tick();
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_start_n", 32'(uart_start_n), 1);
    check("rst_data", 32'(uart_data), 0);
    rst = 1'b0;

    // Single byte, manual handshake
    man_ready = 1'b1;
    push(8'h55);
    check("t1_count_push", 32'(count), 1);
    check("t1_sn_before", 32'(uart_start_n), 1);
    tick();
    check("t1_sn_low0", 32'(uart_start_n), 0);
    check("t1_data", 32'(uart_data), 32'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_sn_low", 32'(uart_start_n), 0);
    end
    tick();
    check("t1_sn_release", 32'(uart_start_n), 1);
    check("t1_data_hold", 32'(uart_data), 32'h55);
    check("t1_count_prepop", 32'(count), 1);
    man_ready = 1'b0;
    tick();
    check("t1_count_pop", 32'(count), 0);
    check("t1_empty_pop", 32'(empty), 1);
    check("t1_data_after", 32'(uart_data), 32'h55);
    man_ready = 1'b1;
    repeat (4) tick();
    check("t1_sn_idle", 32'(uart_start_n), 1);

    // Back-to-back bytes through the transmitter model
    cap_q.delete();
    model_en = 1'b1;
    push(8'hA5);
    push(8'h3C);
    push(8'hFF);
    wait_caps(3, 300, "t2_caps");
    if (cap_q.size() == 3) begin
      check("t2_b0", 32'(cap_q[0]), 32'hA5);
      check("t2_b1", 32'(cap_q[1]), 32'h3C);
      check("t2_b2", 32'(cap_q[2]), 32'hFF);
    end
    repeat (FRAME + 5) tick();
    check("t2_empty", 32'(empty), 1);
    check("t2_overflow", 32'(overflow), 0);
    man_ready = 1'b0;
    model_en  = 1'b0;

    // Fill to full, then push coincident with a pop, then overflow
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    check("t3_full", 32'(full), 1);
    check("t3_count16", 32'(count), 16);
    check("t3_ovf_none", 32'(overflow), 0);
    check("t3_no_req", 32'(uart_start_n), 1);
    man_ready = 1'b1;
    wait_sn(1'b0, 5, "t4_req_low");
    wait_sn(1'b1, 10, "t4_req_high");
    check("t4_head", 32'(uart_data), 32'h10);
    man_ready = 1'b0;
    push(8'hC0);
    check("t4_count", 32'(count), 16);
    check("t4_full", 32'(full), 1);
    check("t4_ovf", 32'(overflow), 0);
    push(8'hEE);
    check("t3_drop_count", 32'(count), 16);
    check("t3_ovf", 32'(overflow), 1);
    cap_q.delete();
    model_en = 1'b1;
    wait_caps(16, 800, "t3_caps");
    if (cap_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        exp_b = (i < 15) ? (8'h11 + 8'(i)) : 8'hC0;
        check($sformatf("t3_b%0d", i), 32'(cap_q[i]), 32'(exp_b));
      end
    end
    repeat (FRAME + 10) tick();
    check("t3_no_17th", 32'(cap_q.size()), 16);
    check("t3_empty", 32'(empty), 1);
    check("t3_ovf_sticky", 32'(overflow), 1);
    model_en  = 1'b0;
    man_ready = 1'b0;

    // Reset while waiting for the transmitter to go busy
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    man_ready = 1'b1;
    wait_sn(1'b0, 5, "t5_req_low");
    wait_sn(1'b1, 10, "t5_req_high");
    check("t5_count_pre", 32'(count), 5);
    rst = 1'b1;
    tick();
    check("t5_count", 32'(count), 0);
    check("t5_empty", 32'(empty), 1);
    check("t5_full", 32'(full), 0);
    check("t5_sn", 32'(uart_start_n), 1);
    check("t5_data", 32'(uart_data), 0);
    check("t5_ovf", 32'(overflow), 0);
    rst = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!uart_start_n) seen_low = 1'b1;
    end
    check("t5_no_req", 32'(seen_low), 0);

    // Transmitter not ready for a long time after reset
    man_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    push(8'h9A);
    seen_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!uart_start_n) seen_low = 1'b1;
    end
    check("t6_hold_off", 32'(seen_low), 0);
    man_ready = 1'b1;
    tick();
    check("t6_req", 32'(uart_start_n), 0);
    check("t6_data", 32'(uart_data), 32'h9A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
